// File: rtl/obi_data_if_arbiter.sv
// Round-robin arbiter sharing one OBI data manager port among NumIfs core data interfaces.
// Holds an ungranted request stable and routes in-order responses back through a small FIFO.
module obi_data_if_arbiter #(
  parameter int unsigned NumIfs         = 2,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumIfs-1:0]                    s_req_i,
  input  logic [NumIfs-1:0]                    s_we_i,
  input  logic [NumIfs*4-1:0]                  s_be_i,
  input  logic [NumIfs*32-1:0]                 s_addr_i,
  input  logic [NumIfs*32-1:0]                 s_wdata_i,
  output logic [NumIfs-1:0]                    s_gnt_o,
  output logic [NumIfs-1:0]                    s_rvalid_o,
  output logic [NumIfs*32-1:0]                 s_rdata_o,
  output logic                                 m_req_o,
  output logic                                 m_we_o,
  output logic [3:0]                           m_be_o,
  output logic [31:0]                          m_addr_o,
  output logic [31:0]                          m_wdata_o,
  input  logic                                 m_gnt_i,
  input  logic                                 m_rvalid_i,
  input  logic [31:0]                          m_rdata_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 err_o
);

  localparam int unsigned IdxW = (NumIfs > 1) ? $clog2(NumIfs) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic            lock_q, lock_d;
  logic            err_q, err_d;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [IdxW-1:0] sel, head;
  logic            sel_valid, full, empty, hs, pop;
  int unsigned     idx;

  // Scan downwards so the last hit is the first requester at or after rr_q.
  always_comb begin
    sel       = lock_idx_q;
    sel_valid = lock_q;
    idx       = 0;
    if (!lock_q) begin
      sel = '0;
      for (int unsigned k = 0; k < NumIfs; k++) begin
        idx = 32'(rr_q) + (NumIfs - 1 - k);
        if (idx >= NumIfs) idx = idx - NumIfs;
        if (s_req_i[IdxW'(idx)]) begin
          sel       = IdxW'(idx);
          sel_valid = 1'b1;
        end
      end
    end
  end

  assign full  = (32'(cnt_q) == MaxOutstanding);
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rptr_q];

  assign m_req_o   = ((|s_req_i) | lock_q) & ~full;
  assign m_we_o    = sel_valid & s_we_i[sel];
  assign m_be_o    = sel_valid ? s_be_i[32'(sel)*4 +: 4] : '0;
  assign m_addr_o  = sel_valid ? s_addr_i[32'(sel)*32 +: 32] : '0;
  assign m_wdata_o = sel_valid ? s_wdata_i[32'(sel)*32 +: 32] : '0;

  assign hs  = m_req_o & m_gnt_i;
  assign pop = m_rvalid_i & ~empty;

  assign s_rdata_o     = {NumIfs{m_rdata_i}};
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  always_comb begin
    s_gnt_o    = '0;
    s_rvalid_o = '0;
    if (hs)  s_gnt_o[sel]     = 1'b1;
    if (pop) s_rvalid_o[head] = 1'b1;
  end

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q | (m_rvalid_i & empty);
    if (hs) begin
      rr_d   = (32'(sel) == NumIfs - 1) ? '0 : sel + 1'b1;
      lock_d = 1'b0;
      wptr_d = (32'(wptr_q) == MaxOutstanding - 1) ? '0 : wptr_q + 1'b1;
    end else if (m_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end
    if (pop) begin
      rptr_d = (32'(rptr_q) == MaxOutstanding - 1) ? '0 : rptr_q + 1'b1;
    end
    unique case ({hs, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Entries need no reset: only slots between rptr and wptr are ever read.
  always_ff @(posedge clk_i) begin
    if (!rst_i && hs) fifo_q[wptr_q] <= sel;
  end

endmodule

// File: tb/tb_obi_data_if_arbiter.sv
// Directed bench for obi_data_if_arbiter: expected grants/responses are queued by the stimulus
// and consumed by an independent monitor on the falling edge.
module tb_obi_data_if_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  s_req_i, s_we_i, s_gnt_o, s_rvalid_o;
  logic [7:0]  s_be_i;
  logic [63:0] s_addr_i, s_wdata_i, s_rdata_o;
  logic        m_req_o, m_we_o, m_gnt_i, m_rvalid_i, err_o;
  logic [3:0]  m_be_o;
  logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;
  logic [1:0]  outstanding_o;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } rsp_t;

  int   gnt_q [$];
  rsp_t rsp_q [$];
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  obi_data_if_arbiter #(.NumIfs(2), .MaxOutstanding(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .s_req_i      (s_req_i),
    .s_we_i       (s_we_i),
    .s_be_i       (s_be_i),
    .s_addr_i     (s_addr_i),
    .s_wdata_i    (s_wdata_i),
    .s_gnt_o      (s_gnt_o),
    .s_rvalid_o   (s_rvalid_o),
    .s_rdata_o    (s_rdata_o),
    .m_req_o      (m_req_o),
    .m_we_o       (m_we_o),
    .m_be_o       (m_be_o),
    .m_addr_o     (m_addr_o),
    .m_wdata_o    (m_wdata_o),
    .m_gnt_i      (m_gnt_i),
    .m_rvalid_i   (m_rvalid_i),
    .m_rdata_i    (m_rdata_i),
    .outstanding_o(outstanding_o),
    .err_o        (err_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addr_of(input int i);
    return (i == 0) ? 32'h200 : 32'h100;
  endfunction

  function automatic logic [31:0] wdata_of(input int i);
    return (i == 0) ? 32'h1111_0000 : 32'h2222_0000;
  endfunction

  function automatic logic [3:0] be_of(input int i);
    return (i == 0) ? 4'h3 : 4'hC;
  endfunction

  // Monitor: consumes expectations whenever the DUT handshakes or a response arrives.
  always @(negedge clk) begin
    int   e;
    rsp_t r;
    if (!rst_i) begin
      if (m_req_o && m_gnt_i) begin
        if (gnt_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_grant: got s_gnt_o=%b, expected no handshake", s_gnt_o);
        end else begin
          e = gnt_q.pop_front();
          check("grant_onehot", 64'(s_gnt_o), 64'(1 << e));
          check("grant_addr", 64'(m_addr_o), 64'(addr_of(e)));
          check("grant_wdata", 64'(m_wdata_o), 64'(wdata_of(e)));
          check("grant_be", 64'(m_be_o), 64'(be_of(e)));
          check("grant_we", 64'(m_we_o), 64'(e == 1));
        end
      end else begin
        check("no_grant", 64'(s_gnt_o), 64'd0);
      end
      if (m_rvalid_i) begin
        if (rsp_q.size() == 0) begin
          check("spurious_rvalid", 64'(s_rvalid_o), 64'd0);
        end else begin
          r = rsp_q.pop_front();
          check("rvalid_route", 64'(s_rvalid_o), 64'(1 << r.idx));
          check("rdata", 64'(s_rdata_o[r.idx*32 +: 32]), 64'(r.data));
        end
      end else begin
        check("no_rvalid", 64'(s_rvalid_o), 64'd0);
      end
    end
  end

  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                       input logic [31:0] rdata);
    s_req_i    = req;
    m_gnt_i    = gnt;
    m_rvalid_i = rv;
    m_rdata_i  = rdata;
  endtask

  initial begin
    rst_i     = 1'b1;
    s_we_i    = 2'b10;
    s_be_i    = {4'hC, 4'h3};
    s_addr_i  = {32'h100, 32'h200};
    s_wdata_i = {32'h2222_0000, 32'h1111_0000};
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    repeat (2) step();

    // Reset state with all inputs low
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_m_req", 64'(m_req_o), 64'd0);
    check("rst_outstanding", 64'(outstanding_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_addr", 64'(m_addr_o), 64'd0);
    check("rst_be", 64'(m_be_o), 64'd0);

    // Contention: grants alternate 0,1,0,...; each response one cycle after its grant
    for (int i = 0; i < 8; i++) begin
      step();
      drive((i < 7) ? 2'b11 : 2'b00, i < 7, i > 0, 32'hC000_0000 + 32'(i));
      if (i < 7) gnt_q.push_back(i % 2);
      if (i > 0) rsp_q.push_back('{(i - 1) % 2, 32'hC000_0000 + 32'(i)});
      @(negedge clk);
      check("cont_outstanding", 64'(outstanding_o), (i > 0) ? 64'd1 : 64'd0);
    end

    // Lock: rr now points at if1, but if0 requested first and must stay on the bus
    for (int i = 0; i < 3; i++) begin
      step();
      drive((i == 2) ? 2'b11 : 2'b01, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check("lock_m_req", 64'(m_req_o), 64'd1);
      check("lock_addr", 64'(m_addr_o), 64'h200);
    end
    step();
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    gnt_q.push_back(0);
    @(negedge clk);
    check("lock_gnt", 64'(s_gnt_o), 64'b01);
    step();
    gnt_q.push_back(1);
    @(negedge clk);
    check("lock_next_gnt", 64'(s_gnt_o), 64'b10);
    step();
    drive(2'b00, 1'b0, 1'b1, 32'h1234_0000);
    rsp_q.push_back('{0, 32'h1234_0000});
    step();
    drive(2'b00, 1'b0, 1'b1, 32'h1234_0001);
    rsp_q.push_back('{1, 32'h1234_0001});
    step();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("lock_drained", 64'(outstanding_o), 64'd0);

    // Full: two handshakes fill the FIFO, request drops until a response frees a slot
    step();
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    gnt_q.push_back(0);
    step();
    gnt_q.push_back(1);
    step();
    @(negedge clk);
    check("full_m_req", 64'(m_req_o), 64'd0);
    check("full_outstanding", 64'(outstanding_o), 64'd2);
    step();
    drive(2'b11, 1'b1, 1'b1, 32'hF000_0000);
    rsp_q.push_back('{0, 32'hF000_0000});
    @(negedge clk);
    check("full_pop_outstanding", 64'(outstanding_o), 64'd2);
    step();
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    gnt_q.push_back(0);
    @(negedge clk);
    check("full_reassert", 64'(m_req_o), 64'd1);
    step();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("full_refill", 64'(outstanding_o), 64'd2);
    step();
    drive(2'b00, 1'b0, 1'b1, 32'hF000_0001);
    rsp_q.push_back('{1, 32'hF000_0001});
    step();
    drive(2'b00, 1'b0, 1'b1, 32'hF000_0002);
    rsp_q.push_back('{0, 32'hF000_0002});
    step();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("full_drained", 64'(outstanding_o), 64'd0);

    // Routing: if1 then if0, responses must come back in grant order
    step();
    drive(2'b10, 1'b1, 1'b0, 32'h0);
    gnt_q.push_back(1);
    @(negedge clk);
    check("route_addr1", 64'(m_addr_o), 64'h100);
    step();
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    gnt_q.push_back(0);
    @(negedge clk);
    check("route_addr0", 64'(m_addr_o), 64'h200);
    step();
    drive(2'b00, 1'b0, 1'b1, 32'h0000_AAAA);
    rsp_q.push_back('{1, 32'h0000_AAAA});
    step();
    drive(2'b00, 1'b0, 1'b1, 32'h0000_BBBB);
    rsp_q.push_back('{0, 32'h0000_BBBB});
    step();
    drive(2'b00, 1'b0, 1'b0, 32'h0);

    // Spurious response with the FIFO empty
    step();
    drive(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("spur_err_before", 64'(err_o), 64'd0);
    step();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("spur_err_sticky", 64'(err_o), 64'd1);
      step();
    end

    // Reset mid-operation: one outstanding, lock held on if0, rr pointing at if1
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    gnt_q.push_back(0);
    step();
    drive(2'b01, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("pre_rst_outstanding", 64'(outstanding_o), 64'd1);
    step();
    rst_i = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    step();
    rst_i = 1'b0;
    drive(2'b00, 1'b0, 1'b1, 32'h5555_5555);
    @(negedge clk);
    check("rst_mid_outstanding", 64'(outstanding_o), 64'd0);
    check("rst_mid_m_req", 64'(m_req_o), 64'd0);
    check("rst_mid_addr", 64'(m_addr_o), 64'd0);
    check("rst_mid_err", 64'(err_o), 64'd0);
    step();
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    gnt_q.push_back(0);
    @(negedge clk);
    check("rst_inflight_err", 64'(err_o), 64'd1);
    step();
    drive(2'b00, 1'b0, 1'b1, 32'h7777_0000);
    rsp_q.push_back('{0, 32'h7777_0000});
    step();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("final_outstanding", 64'(outstanding_o), 64'd0);
    check("grants_consumed", 64'(gnt_q.size()), 64'd0);
    check("responses_consumed", 64'(rsp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
